// File: rtl/aes_pkg.sv
// Shared AES-128 constants: round count, round-constant table and sequencer states.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_ROUND = 2'd1,
        FSM_DONE  = 2'd2
    } fsm_e;

    // RCON[1..10]; index 0 and 11..15 never occur in a valid round and return 0.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule; word 0 is bits 127:96.
module aes_key_step (
    input  logic [127:0] k,
    input  logic [7:0]   rc,
    output logic [127:0] k_next
);

    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] w0, w1, w2, w3;

    assign rot_w = {k[23:0], k[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .a (rot_w[8*i +: 8]),
            .y (sub_w[8*i +: 8])
        );
    end

    always_comb begin
        w0     = k[127:96] ^ sub_w ^ {rc, 24'h000000};
        w1     = k[95:64]  ^ w0;
        w2     = k[63:32]  ^ w1;
        w3     = k[31:0]   ^ w2;
        k_next = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_sbox.sv
// AES byte S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_EXP = 8'hfe;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse for x != 0 and maps 0 to 0, matching the S-box definition.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 controller: initial AddRoundKey, on-the-fly key schedule and
// one external round-datapath evaluation per clock, with valid/ready on both sides.
module aes128_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] Test,
    input  logic [DW-1:0] Key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Code,
    output logic [DW-1:0] rnd_data,
    output logic [DW-1:0] rnd_key,
    output logic          last_round,
    input  logic [DW-1:0] rnd_result,
    output logic          busy
);

    fsm_e          fsm_q, fsm_d;
    logic [DW-1:0] state_q, state_d;
    logic [DW-1:0] key_q, key_d;
    logic [3:0]    rnd_q, rnd_d;

    logic [DW-1:0] step_key;
    logic          in_round;
    logic          is_last;

    aes_key_step u_key_step (
        .k      (key_q),
        .rc     (rcon_lookup(rnd_q)),
        .k_next (step_key)
    );

    assign in_round = (fsm_q == FSM_ROUND);
    assign is_last  = (rnd_q == 4'(NR));

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            FSM_IDLE: begin
                if (in_valid) begin
                    state_d = Test ^ Key;
                    key_d   = Key;
                    rnd_d   = 4'd1;
                    fsm_d   = FSM_ROUND;
                end
            end
            FSM_ROUND: begin
                state_d = rnd_result;
                key_d   = step_key;
                // The counter stops at NR so it never leaves the RCON range.
                if (is_last) fsm_d = FSM_DONE;
                else         rnd_d = rnd_q + 4'd1;
            end
            FSM_DONE: begin
                if (out_ready) fsm_d = FSM_IDLE;
            end
            default: fsm_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= FSM_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    // Datapath-facing outputs are forced to zero outside ROUND to keep it quiet.
    always_comb begin
        in_ready   = (fsm_q == FSM_IDLE);
        out_valid  = (fsm_q == FSM_DONE);
        busy       = in_round;
        Code       = out_valid ? state_q : '0;
        rnd_data   = in_round ? state_q : '0;
        rnd_key    = in_round ? step_key : '0;
        last_round = in_round & is_last;
    end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: models the round datapath and a full AES-128 reference.
module tb_aes128_round_sequencer;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CODE_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CODE_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] Test = '0;
    logic [127:0] Key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] Code;
    logic [127:0] rnd_data;
    logic [127:0] rnd_key;
    logic         last_round;
    logic [127:0] rnd_result;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sbox_tbl [256];

    always #5 clk = ~clk;

    aes128_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Test       (Test),
        .Key        (Key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Code       (Code),
        .rnd_data   (rnd_data),
        .rnd_key    (rnd_key),
        .last_round (last_round),
        .rnd_result (rnd_result),
        .busy       (busy)
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search plus the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tbl[x] = s;
        end
    endtask

    // Behavioural round datapath: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
    function automatic logic [127:0] tb_round(input logic [127:0] st, input logic [127:0] k,
                                              input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox_tbl[st[127 - 8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c+0] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
                a[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
            end
            for (int i = 0; i < 16; i++) b[i] = a[i];
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] ref_key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox_tbl[t[8*i +: 8]];
        t = t ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] rk;
        logic [7:0]   rc;
        s  = pt ^ key;
        rk = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = ref_key_next(rk, rc);
            s  = tb_round(s, rk, r == 10);
            rc = xtime(rc);
        end
        return s;
    endfunction

    assign rnd_result = tb_round(rnd_data, rnd_key, last_round);

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Latency is counted in edges including the accepting edge.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_code, input logic [127:0] exp_rk1,
                             input int stall, input bit junk);
        int edges;
        int lr;
        check_eq("idle_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        Test     = pt;
        Key      = key;
        tick();
        in_valid = 1'b0;
        Test     = rand128();
        Key      = rand128();
        check_eq("round1_key", rnd_key, exp_rk1);
        check_eq("round1_busy", 128'(busy), 128'd1);
        check_eq("round1_data", rnd_data, pt ^ key);
        edges = 1;
        lr    = 0;
        while (!out_valid && edges < 40) begin
            if (last_round) lr++;
            tick();
            edges++;
        end
        check_eq("latency", 128'(edges), 128'd11);
        check_eq("last_round_cycles", 128'(lr), 128'd1);
        check_eq("code", Code, exp_code);
        check_eq("done_busy", 128'(busy), 128'd0);
        for (int i = 0; i < stall; i++) begin
            if (junk && i == stall / 2) begin
                in_valid = 1'b1;
                Test     = rand128();
                Key      = rand128();
            end
            tick();
            in_valid = 1'b0;
            check_eq("stall_code", Code, exp_code);
            check_eq("stall_in_ready", 128'(in_ready), 128'd0);
            check_eq("stall_valid", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_hs_valid", 128'(out_valid), 128'd0);
        check_eq("post_hs_in_ready", 128'(in_ready), 128'd1);
        tick();
        check_eq("post_hs_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        int           cyc;
        int           nv;
        int           lr;
        int           t_v [2];
        logic [127:0] c_v [2];
        logic [127:0] pt;
        logic [127:0] key;

        build_sbox();
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_last_round", 128'(last_round), 128'd0);
        check_eq("rst_code", Code, 128'd0);
        tick();
        rst = 1'b0;
        tick();

        run_block(PT_B, KEY_B, CODE_B, RK1_B, 0, 1'b0);
        run_block(PT_C, KEY_C, CODE_C, ref_key_next(KEY_C, 8'h01), 0, 1'b0);
        run_block(PT_B, KEY_B, CODE_B, RK1_B, 20, 1'b1);

        // Back-to-back with in_valid and out_ready both held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        Test      = PT_B;
        Key       = KEY_B;
        tick();
        Test = PT_C;
        Key  = KEY_C;
        cyc  = 1;
        nv   = 0;
        lr   = 0;
        t_v  = '{0, 0};
        c_v  = '{128'd0, 128'd0};
        while (nv < 2 && cyc < 60) begin
            if (last_round) lr++;
            if (out_valid) begin
                t_v[nv] = cyc;
                c_v[nv] = Code;
                nv++;
                if (nv == 2) in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check_eq("b2b_count", 128'(nv), 128'd2);
        check_eq("b2b_code0", c_v[0], CODE_B);
        check_eq("b2b_code1", c_v[1], CODE_C);
        check_eq("b2b_spacing", 128'(t_v[1] - t_v[0]), 128'd12);
        check_eq("b2b_last_rounds", 128'(lr), 128'd2);
        check_eq("b2b_end_in_ready", 128'(in_ready), 128'd1);
        tick();

        // Asynchronous reset at round 5 of a block in flight.
        in_valid = 1'b1;
        Test     = PT_C;
        Key      = KEY_C;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("pre_rst_busy", 128'(busy), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_in_ready", 128'(in_ready), 128'd1);
        check_eq("arst_out_valid", 128'(out_valid), 128'd0);
        check_eq("arst_busy", 128'(busy), 128'd0);
        check_eq("arst_last_round", 128'(last_round), 128'd0);
        check_eq("arst_code", Code, 128'd0);
        check_eq("arst_rnd_data", rnd_data, 128'd0);
        check_eq("arst_rnd_key", rnd_key, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_valid", 128'(out_valid), 128'd0);
        run_block(PT_B, KEY_B, CODE_B, RK1_B, 0, 1'b0);

        // Randomized blocks against the reference model.
        for (int n = 0; n < 8; n++) begin
            pt  = rand128();
            key = rand128();
            run_block(pt, key, ref_encrypt(pt, key), ref_key_next(key, 8'h01),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Idle stability.
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("idle_rnd_data", rnd_data, 128'd0);
            check_eq("idle_rnd_key", rnd_key, 128'd0);
            check_eq("idle_busy", 128'(busy), 128'd0);
            check_eq("idle_out_valid", 128'(out_valid), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
